// File: rtl/astro_pkg.sv
// astro_pkg: shared types and constants for the Astrocade ROM loader.
//   loader_state_t          : byte-serialiser FSM states
//   IDX_BIOS / IDX_CART     : ioctl_index values this loader accepts
//   MASK_2K / MASK_4K / MASK_8K : cartridge mirror masks (byte address)
package astro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } loader_state_t;

    localparam logic [7:0]  IDX_BIOS = 8'd0;
    localparam logic [7:0]  IDX_CART = 8'd1;

    localparam logic [15:0] MASK_2K  = 16'h07FF;
    localparam logic [15:0] MASK_4K  = 16'h0FFF;
    localparam logic [15:0] MASK_8K  = 16'h1FFF;

endpackage

// File: rtl/astro_size_mask.sv
// astro_size_mask: maps the loaded cartridge size onto a power-of-two
// mirror mask so small carts repeat across the whole cartridge window.
//   cart_size in  16      bytes loaded (highest byte + 1)
//   mask      out ADDR_W  AND-mask applied to the CPU cart address
// Purely combinational.
module astro_size_mask
    import astro_pkg::*;
#(
    parameter int ADDR_W = 13
)
(
    input  logic [15:0]       cart_size,
    output logic [ADDR_W-1:0] mask
);

    always_comb begin
        mask = '1;
        // An empty cart or anything above 4K sees the full window unmasked.
        if (cart_size == 16'd0)
            mask = '1;
        else if (cart_size <= 16'd2048)
            mask = ADDR_W'(MASK_2K);
        else if (cart_size <= 16'd4096)
            mask = ADDR_W'(MASK_4K);
    end

endmodule

// File: rtl/astro_rom_loader.sv
// astro_rom_loader: splits 16-bit HPS download words into two byte writes
// for the BIOS / cartridge block RAMs, tracks cartridge size, and mirrors
// the CPU cartridge address through a size-derived mask during play.
//   clk_sys, reset                 clock, async active-high reset
//   ioctl_download/index/wr/addr/dout  HPS download port (in)
//   ioctl_wait                     registered stall while a word is split
//   cpu_cart_addr, cpu_bios_addr   CPU-side RAM addresses (in)
//   cart_addr, bios_addr           RAM addresses (loader or CPU source)
//   mem_din, cart_we, bios_we      shared write byte and per-RAM enables
//   cart_size, cart_loaded         cart size (saturating) and load status
module astro_rom_loader
    import astro_pkg::*;
#(
    parameter int ADDR_W = 13
)
(
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    output logic              ioctl_wait,
    input  logic [ADDR_W-1:0] cpu_cart_addr,
    input  logic [ADDR_W-1:0] cpu_bios_addr,
    output logic [ADDR_W-1:0] cart_addr,
    output logic [ADDR_W-1:0] bios_addr,
    output logic [7:0]        mem_din,
    output logic              cart_we,
    output logic              bios_we,
    output logic [15:0]       cart_size,
    output logic              cart_loaded
);

    localparam logic [25:0] WIN = 26'd1 << ADDR_W;

    loader_state_t     state;
    logic [24:0]       lat_addr;
    logic [7:0]        lat_hi;
    logic              lat_cart;
    logic [ADDR_W-1:0] ld_addr;
    logic [ADDR_W-1:0] mask_q;
    logic [ADDR_W-1:0] mask_new;
    logic              dl_q;
    logic              dl_cart;
    logic              fin_pend;

    function automatic logic [15:0] sat16(input logic [25:0] v);
        return (v > 26'h00FFFF) ? 16'hFFFF : v[15:0];
    endfunction

    logic        is_cart_idx, idx_ok, start, rise, fall, fin_req, sel_ldr;
    logic [25:0] lo_end, hi_byte;
    logic [15:0] lo_sz, hi_sz, size_base;

    assign is_cart_idx = (ioctl_index == IDX_CART);
    assign idx_ok      = is_cart_idx | (ioctl_index == IDX_BIOS);
    assign start       = ioctl_download & ioctl_wr & idx_ok;
    assign rise        = ioctl_download & ~dl_q;
    assign fall        = ~ioctl_download & dl_q;
    // A finish that lands while a word is in flight is held until IDLE.
    assign fin_req     = (fall & dl_cart) | fin_pend;

    assign lo_end    = {1'b0, ioctl_addr} + 26'd1;
    assign hi_byte   = {1'b0, lat_addr} + 26'd1;
    assign lo_sz     = sat16(lo_end);
    assign hi_sz     = sat16(hi_byte + 26'd1);
    assign size_base = (rise & is_cart_idx) ? 16'd0 : cart_size;

    astro_size_mask #(.ADDR_W(ADDR_W)) u_size_mask (
        .cart_size (cart_size),
        .mask      (mask_new)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ioctl_wait  <= 1'b0;
            cart_we     <= 1'b0;
            bios_we     <= 1'b0;
            mem_din     <= 8'd0;
            cart_size   <= 16'd0;
            cart_loaded <= 1'b0;
            mask_q      <= '1;
            lat_addr    <= '0;
            lat_hi      <= 8'd0;
            lat_cart    <= 1'b0;
            ld_addr     <= '0;
            dl_q        <= 1'b0;
            dl_cart     <= 1'b0;
            fin_pend    <= 1'b0;
        end else begin
            dl_q <= ioctl_download;

            if (fin_req) begin
                if (state == IDLE) begin
                    mask_q      <= mask_new;
                    cart_loaded <= (cart_size != 16'd0);
                    fin_pend    <= 1'b0;
                end else begin
                    fin_pend    <= 1'b1;
                end
            end

            // Placed after the finish block so a new cart download wins.
            if (rise) begin
                dl_cart <= is_cart_idx;
                if (is_cart_idx) begin
                    cart_size   <= 16'd0;
                    cart_loaded <= 1'b0;
                    mask_q      <= '1;
                    fin_pend    <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    cart_we <= 1'b0;
                    bios_we <= 1'b0;
                    if (start) begin
                        lat_addr   <= ioctl_addr;
                        lat_hi     <= ioctl_dout[15:8];
                        lat_cart   <= is_cart_idx;
                        ld_addr    <= ioctl_addr[ADDR_W-1:0];
                        mem_din    <= ioctl_dout[7:0];
                        cart_we    <= ({1'b0, ioctl_addr} < WIN) &  is_cart_idx;
                        bios_we    <= ({1'b0, ioctl_addr} < WIN) & ~is_cart_idx;
                        ioctl_wait <= 1'b1;
                        state      <= WR_LO;
                        if (is_cart_idx && lo_sz > size_base)
                            cart_size <= lo_sz;
                    end
                end
                WR_LO: begin
                    ld_addr <= hi_byte[ADDR_W-1:0];
                    mem_din <= lat_hi;
                    cart_we <= (hi_byte < WIN) &  lat_cart;
                    bios_we <= (hi_byte < WIN) & ~lat_cart;
                    state   <= WR_HI;
                    if (lat_cart && hi_sz > cart_size)
                        cart_size <= hi_sz;
                end
                WR_HI: begin
                    cart_we    <= 1'b0;
                    bios_we    <= 1'b0;
                    ioctl_wait <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    cart_we    <= 1'b0;
                    bios_we    <= 1'b0;
                    ioctl_wait <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Loader owns the RAM address until the download ends, the FSM drains,
    // and any deferred mask update has been applied.
    assign sel_ldr   = ioctl_download | (state != IDLE) | fin_pend;
    assign cart_addr = sel_ldr ? ld_addr : (cpu_cart_addr & mask_q);
    assign bios_addr = sel_ldr ? ld_addr : cpu_bios_addr;

endmodule
